// File: rtl/order_decode_stage.sv
// order_decode_stage: decode / operand-fetch stage between fetch and execute.
// Decodes the 32-bit order word, reads operands from the flattened register
// file with bypass from later stages, and stalls on scoreboarded hazards.
// Valid/ready handshakes on both sides; one registered output stage.

// Per-channel slice: bypass selection plus the scoreboard hold counter.
module order_decode_chan #(
    parameter int DW   = 32,
    parameter int NFWD = 2,
    parameter int LAT  = 3,
    parameter int CH   = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DW-1:0]       reg_val,
    input  logic [NFWD-1:0]     fwd_valid,
    input  logic [4*NFWD-1:0]   fwd_ch,
    input  logic [DW*NFWD-1:0]  fwd_data,
    input  logic                flush,
    input  logic                load,
    output logic [DW-1:0]       val,
    output logic                hazard
);
    localparam int CW = $clog2(LAT + 1);
    localparam logic [CW-1:0] LAT_C = CW'(LAT);

    logic [CW-1:0] cnt;
    logic          hit;
    logic [DW-1:0] fwd_val;

    // Bypass match; scanning high to low lets the lowest port index win.
    always_comb begin
        hit     = 1'b0;
        fwd_val = '0;
        for (int p = NFWD - 1; p >= 0; p--) begin
            if (fwd_valid[p] && (fwd_ch[p*4 +: 4] == 4'(CH))) begin
                hit     = 1'b1;
                fwd_val = fwd_data[p*DW +: DW];
            end
        end
    end

    // Channel 0 is the hard zero; a live bypass covers a pending write.
    always_comb begin
        val    = (CH == 0) ? '0 : (hit ? fwd_val : reg_val);
        hazard = (cnt != '0) && !hit;
    end

    // Hold counter: flush clears, reload beats decrement.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LAT_C;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end
endmodule

module order_decode_stage #(
    parameter int DW   = 32,
    parameter int NFWD = 2,
    parameter int LAT  = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_order,
    input  logic [DW-1:0]       in_addr,
    input  logic                in_irq,
    input  logic [7:0]          in_irq_num,
    input  logic                flush,
    input  logic [16*DW-1:0]    regs,
    input  logic [NFWD-1:0]     fwd_valid,
    input  logic [4*NFWD-1:0]   fwd_ch,
    input  logic [DW*NFWD-1:0]  fwd_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4:0]          out_mode,
    output logic                out_rw,
    output logic [1:0]          out_sub,
    output logic [DW-1:0]       out_x1,
    output logic [DW-1:0]       out_x2,
    output logic [DW-1:0]       out_inum,
    output logic [4:0]          out_m,
    output logic [4:0]          out_l,
    output logic [3:0]          out_x1_ch,
    output logic [3:0]          out_x2_ch,
    output logic [3:0]          out_y1_ch,
    output logic [1:0]          out_y2_ch,
    output logic [DW-1:0]       out_addr,
    output logic                out_irq,
    output logic [7:0]          out_irq_num,
    output logic                out_four,
    output logic [15:0]         stall_cnt
);
    typedef struct packed {
        logic [4:0]  mode;
        logic        rw;
        logic [1:0]  sub;
        logic [3:0]  x1;
        logic [3:0]  x2;
        logic [3:0]  y1;
        logic [1:0]  y2;
        logic [20:0] inum;
        logic [4:0]  m;
        logic [4:0]  l;
        logic        four;
    } dec_t;

    logic [4:0] op;
    logic       g1_9, g18_22, g20_22, g16_17, g_alu;
    dec_t       d;
    dec_t       q;

    logic [15:0][DW-1:0] chan_val;
    logic [15:0]         chan_haz;
    logic [15:0]         chan_ld;

    logic [DW-1:0] inum_ext;
    logic [DW-1:0] x1_val, x2_val;
    logic          src_haz, stall, accept;

    logic [DW-1:0] x1_q, x2_q, addr_q;
    logic          irq_q;
    logic [7:0]    irq_num_q;

    assign op = in_order[31:27];

    // Field decode of the order word.
    always_comb begin
        d      = '0;
        g1_9   = (op >= 5'd1)  && (op <= 5'd9);
        g18_22 = (op >= 5'd18) && (op <= 5'd22);
        g20_22 = (op >= 5'd20) && (op <= 5'd22);
        g16_17 = (op == 5'd16) || (op == 5'd17);
        g_alu  = (op == 5'd1) || (op == 5'd2) || (op == 5'd3) ||
                 (op == 5'd5) || (op == 5'd6);

        if (g1_9 || g16_17 || g18_22) d.mode = op;

        if (((op >= 5'd1) && (op <= 5'd7)) || (op == 5'd9) || g18_22)
            d.x1 = in_order[23:20];
        else if (op == 5'd17)
            d.x1 = in_order[24:21];
        else if (op == 5'd8)
            d.x1 = 4'd13;

        if (g1_9 || g18_22) d.x2 = in_order[19:16];

        if (g1_9 || g18_22)  d.sub = in_order[25:24];
        else if (g16_17)     d.sub = in_order[26:25];

        if (g1_9 || g20_22)  d.rw = in_order[26];
        else if (op == 5'd17) d.rw = 1'b1;

        if ((op == 5'd4) || (op == 5'd9) || (op == 5'd18))
            d.y1 = d.x1;
        else if (op == 5'd19)
            d.y1 = in_order[23:20];
        else if (op == 5'd16)
            d.y1 = in_order[24:21];
        else if (g_alu)
            d.y1 = in_order[15:12];
        else if ((op == 5'd7) && !d.rw)
            d.y1 = d.x1;
        else if ((op == 5'd8) && !d.rw)
            d.y1 = d.x2;

        if (((op >= 5'd1) && (op <= 5'd6)) || (op == 5'd17) || g20_22)
            d.y2 = 2'd1;
        else if (op == 5'd8)
            d.y2 = 2'd2;

        if ((op == 5'd4) || (op == 5'd7) || (op == 5'd8) || (op == 5'd9) ||
            (op == 5'd18) || g20_22)
            d.inum = {5'd0, in_order[15:0]};
        else if (op == 5'd19)
            d.inum = {15'd0, in_order[15:10]};
        else if (g16_17)
            d.inum = in_order[20:0];
        else if (g_alu)
            d.inum = {9'd0, in_order[11:0]};

        if (op == 5'd19) begin
            d.m = in_order[9:5];
            d.l = in_order[4:0];
        end

        d.four = g1_9 || (op == 5'd18);
    end

    assign inum_ext = {{(DW-21){1'b0}}, d.inum};

    // One slice per register channel; reloads target y1, flag (9) or sp (13).
    for (genvar c = 0; c < 16; c++) begin : g_chan
        assign chan_ld[c] = accept && d.four &&
            (((d.y1 == 4'(c)) && (c != 0)) ||
             ((c == 9)  && (d.y2 == 2'd1)) ||
             ((c == 13) && (d.y2 == 2'd2)));

        order_decode_chan #(
            .DW(DW), .NFWD(NFWD), .LAT(LAT), .CH(c)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .reg_val   (regs[c*DW +: DW]),
            .fwd_valid (fwd_valid),
            .fwd_ch    (fwd_ch),
            .fwd_data  (fwd_data),
            .flush     (flush),
            .load      (chan_ld[c]),
            .val       (chan_val[c]),
            .hazard    (chan_haz[c])
        );
    end

    // Operand formation; x2=0 slots carry an immediate or an address sum.
    always_comb begin
        x1_val = chan_val[d.x1];
        x2_val = {{(DW-16){1'b0}}, d.inum[15:0]};
        if (d.x2 != 4'd0)
            x2_val = chan_val[d.x2];
        else if ((d.mode == 5'd16) || (d.mode == 5'd17))
            x2_val = chan_val[13] + inum_ext;
        else if (d.mode == 5'd7)
            x2_val = {chan_val[8][DW-17:0], d.inum[15:0]};
    end

    // Hazard over the source set; channel 0 never hazards.
    always_comb begin
        src_haz = 1'b0;
        if (d.x1 != 4'd0) src_haz = src_haz | chan_haz[d.x1];
        if (d.x2 != 4'd0) src_haz = src_haz | chan_haz[d.x2];
        if ((d.x2 == 4'd0) && ((d.mode == 5'd16) || (d.mode == 5'd17)))
            src_haz = src_haz | chan_haz[13];
        if ((d.x2 == 4'd0) && (d.mode == 5'd7))
            src_haz = src_haz | chan_haz[8];
    end

    // Handshake control.
    always_comb begin
        stall    = in_valid && src_haz;
        in_ready = !flush && !stall && (!out_valid || out_ready);
        accept   = in_valid && in_ready;
    end

    // Output register: flush drops, accept loads, consume clears valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            q         <= '0;
            x1_q      <= '0;
            x2_q      <= '0;
            addr_q    <= '0;
            irq_q     <= 1'b0;
            irq_num_q <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            q         <= d;
            x1_q      <= x1_val;
            x2_q      <= x2_val;
            addr_q    <= in_addr;
            irq_q     <= in_irq;
            irq_num_q <= in_irq_num;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Saturating count of hazard-stall cycles; flush cycles do not count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (stall && !flush && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    assign out_mode    = q.mode;
    assign out_rw      = q.rw;
    assign out_sub     = q.sub;
    assign out_x1      = x1_q;
    assign out_x2      = x2_q;
    assign out_inum    = {{(DW-21){1'b0}}, q.inum};
    assign out_m       = q.m;
    assign out_l       = q.l;
    assign out_x1_ch   = q.x1;
    assign out_x2_ch   = q.x2;
    assign out_y1_ch   = q.y1;
    assign out_y2_ch   = q.y2;
    assign out_addr    = addr_q;
    assign out_irq     = irq_q;
    assign out_irq_num = irq_num_q;
    assign out_four    = q.four;
endmodule

// File: tb/tb_order_decode_stage.sv
// Directed bench for order_decode_stage (DW=32, NFWD=2, LAT=3).
module tb_order_decode_stage;
    localparam int DW   = 32;
    localparam int NFWD = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid, in_ready;
    logic [31:0]       in_order;
    logic [DW-1:0]     in_addr;
    logic              in_irq;
    logic [7:0]        in_irq_num;
    logic              flush;
    logic [16*DW-1:0]  regs;
    logic [NFWD-1:0]   fwd_valid;
    logic [4*NFWD-1:0] fwd_ch;
    logic [DW*NFWD-1:0] fwd_data;
    logic              out_valid, out_ready;
    logic [4:0]        out_mode, out_m, out_l;
    logic              out_rw, out_irq, out_four;
    logic [1:0]        out_sub, out_y2_ch;
    logic [DW-1:0]     out_x1, out_x2, out_inum, out_addr;
    logic [3:0]        out_x1_ch, out_x2_ch, out_y1_ch;
    logic [7:0]        out_irq_num;
    logic [15:0]       stall_cnt;

    int n_chk  = 0;
    int n_fail = 0;
    int low;

    localparam logic [31:0] WR4  = 32'h0823_4000; // mode 1, x1=2 x2=3 y1=4
    localparam logic [31:0] RD4  = 32'hA040_0055; // mode 20, x1=4, inum 0x55
    localparam logic [31:0] DEC  = 32'h0A23_5123;

    order_decode_stage #(.DW(DW), .NFWD(NFWD), .LAT(3)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_order(in_order),
        .in_addr(in_addr), .in_irq(in_irq), .in_irq_num(in_irq_num),
        .flush(flush), .regs(regs),
        .fwd_valid(fwd_valid), .fwd_ch(fwd_ch), .fwd_data(fwd_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_mode(out_mode), .out_rw(out_rw), .out_sub(out_sub),
        .out_x1(out_x1), .out_x2(out_x2), .out_inum(out_inum),
        .out_m(out_m), .out_l(out_l),
        .out_x1_ch(out_x1_ch), .out_x2_ch(out_x2_ch),
        .out_y1_ch(out_y1_ch), .out_y2_ch(out_y2_ch),
        .out_addr(out_addr), .out_irq(out_irq), .out_irq_num(out_irq_num),
        .out_four(out_four), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid = 1'b0;
        repeat (4) tick();
    endtask

    // Counts cycles with in_ready low, bounded.
    task automatic wait_ready(output int n);
        n = 0;
        #1;
        while (!in_ready && n < 10) begin
            @(posedge clk);
            #2;
            n++;
        end
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_order = '0; in_addr = '0;
        in_irq = 1'b0; in_irq_num = '0; flush = 1'b0;
        fwd_valid = '0; fwd_ch = '0; fwd_data = '0; out_ready = 1'b1;
        for (int c = 0; c < 16; c++) regs[c*DW +: DW] = 32'h0000_0111 * c;
        regs[2*DW +: DW]  = 32'h11;
        regs[3*DW +: DW]  = 32'h22;
        regs[4*DW +: DW]  = 32'h44;
        regs[8*DW +: DW]  = 32'hABCD;
        regs[13*DW +: DW] = 32'h1000;

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_stall_cnt", stall_cnt, 0);
        rst = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 1);

        // Decode
        tick();
        in_valid = 1'b1; in_order = DEC; in_addr = 32'h100;
        in_irq = 1'b1; in_irq_num = 8'h5A;
        #1;
        check("dec_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0; in_irq = 1'b0;
        check("dec_valid", out_valid, 1);
        check("dec_mode", out_mode, 1);
        check("dec_sub", out_sub, 2);
        check("dec_rw", out_rw, 0);
        check("dec_x1", out_x1, 32'h11);
        check("dec_x2", out_x2, 32'h22);
        check("dec_x1_ch", out_x1_ch, 2);
        check("dec_x2_ch", out_x2_ch, 3);
        check("dec_y1", out_y1_ch, 5);
        check("dec_y2", out_y2_ch, 1);
        check("dec_inum", out_inum, 32'h123);
        check("dec_four", out_four, 1);
        check("dec_addr", out_addr, 32'h100);
        check("dec_irq", out_irq, 1);
        check("dec_irq_num", out_irq_num, 8'h5A);
        tick();
        check("dec_valid_clr", out_valid, 0);
        drain();

        // Hazard: LAT cycles of stall
        in_valid = 1'b1; in_order = WR4;
        tick();
        in_order = RD4;
        wait_ready(low);
        check("haz_low_cycles", low, 3);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("haz_valid", out_valid, 1);
        check("haz_mode", out_mode, 20);
        check("haz_x1", out_x1, 32'h44);
        check("haz_x2", out_x2, 32'h55);
        check("haz_stall_cnt", stall_cnt, 3);
        drain();

        // Forwarding clears the hazard in the first stall cycle
        in_valid = 1'b1; in_order = WR4;
        tick();
        in_order = RD4;
        fwd_valid = 2'b11; fwd_ch = {4'd4, 4'd4};
        fwd_data = {32'h0000_0001, 32'hDEAD_BEEF};
        #1;
        check("fwd_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0; fwd_valid = '0;
        check("fwd_x1", out_x1, 32'hDEAD_BEEF);
        check("fwd_stall_cnt", stall_cnt, 3);
        drain();

        // Stack address and ds:imm formation
        in_valid = 1'b1; in_order = 32'h80A0_0010;
        tick();
        check("sp_mode", out_mode, 16);
        check("sp_x2", out_x2, 32'h1010);
        check("sp_y1", out_y1_ch, 5);
        check("sp_x1", out_x1, 0);
        check("sp_four", out_four, 0);
        in_order = 32'h3830_1234;
        tick();
        in_valid = 1'b0;
        check("ds_mode", out_mode, 7);
        check("ds_x2", out_x2, 32'hABCD_1234);
        check("ds_x1", out_x1, 32'h22);
        check("ds_y1", out_y1_ch, 3);
        drain();

        // Backpressure holds outputs
        out_ready = 1'b0;
        in_valid = 1'b1; in_order = DEC;
        tick();
        in_order = 32'hA020_0055;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("bp_in_ready", in_ready, 0);
            check("bp_valid", out_valid, 1);
            check("bp_x1", out_x1, 32'h11);
            check("bp_inum", out_inum, 32'h123);
            tick();
        end
        out_ready = 1'b1; in_order = WR4;
        #1;
        check("bp_release_ready", in_ready, 1);
        tick();
        // Flush with counter for channel 4 loaded
        in_order = RD4; flush = 1'b1;
        #1;
        check("fl_in_ready", in_ready, 0);
        tick();
        flush = 1'b0;
        #1;
        check("fl_valid", out_valid, 0);
        check("fl_in_ready_after", in_ready, 1);
        check("fl_stall_cnt", stall_cnt, 3);
        tick();
        in_valid = 1'b0;
        check("fl_acc_valid", out_valid, 1);
        check("fl_acc_x1", out_x1, 32'h44);
        drain();

        // Two more stall cycles, then async reset with held output
        in_valid = 1'b1; in_order = WR4;
        tick();
        in_valid = 1'b0;
        tick();
        in_valid = 1'b1; in_order = RD4;
        wait_ready(low);
        check("haz2_low_cycles", low, 2);
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("pre_rst_valid", out_valid, 1);
        check("pre_rst_stall_cnt", stall_cnt, 5);
        #2;
        rst = 1'b0;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_stall_cnt", stall_cnt, 0);
        check("arst_mode", out_mode, 0);
        check("arst_x1", out_x1, 0);
        check("arst_x2", out_x2, 0);
        check("arst_inum", out_inum, 0);
        check("arst_y1", out_y1_ch, 0);
        check("arst_four", out_four, 0);
        check("arst_addr", out_addr, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
